bm_frame_scheduler: RTL and testbench
=====================================

Name: bm_frame_scheduler

Overview:
- Sequences the two block matchers (A and B) over the double-buffered third BRAMs that bit_pixel_rotator_bram fills.
- Detects a completed camera image from the writer's image_number.
- For each third in turn (left, then center, then right), launches both matchers. Matcher A takes the top half of the rows and matcher B the bottom half.
- When all three thirds are done, toggles bm_working_buf. This releases the buffer back to the writer's stall logic.

Parameters:
third_cols, 240, pixel columns in the left and right thirds
center_cols, 304, pixel columns in the center third
third_rows, 480, rows per third
num_pix, 16, pixels per BRAM word (wr_cols = cols/num_pix)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
image_number  in  4  writer's completed-image count
enable  in  1  permits starting a new frame; does not abort a frame in progress
bm_working_buf  out  1  toggles once per completed frame; equals LSB of frames_done
bm_idle  out  1  high when the FSM is in ST_IDLE
bm_start_a  out  1  one-cycle launch pulse to matcher A
bm_start_b  out  1  one-cycle launch pulse to matcher B
bm_done_a  in  1  one-cycle completion pulse from matcher A
bm_done_b  in  1  one-cycle completion pulse from matcher B
bm_third  out  2  third being processed: 0 = left, 1 = center, 2 = right
bm_buf  out  1  buffer being read
bm_wr_cols  out  5  words per row for the current third
bm_base_addr_a  out  16  first word address of matcher A's row range
bm_base_addr_b  out  16  first word address of matcher B's row range
bm_row_count  out  9  rows per matcher = third_rows/2
frame_done  out  1  one-cycle pulse when a frame completes
frames_done  out  4  completed-frame counter, wraps modulo 16
overrun  out  1  sticky error flag

Behaviour:
- Reset values: every output is 0, the state is ST_IDLE, and the done latches are clear. This is with one exception: bm_idle is 1.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately; matcher done pulses that arrive afterwards are ignored.
- Pending-frame condition: pending = (image_number != frames_done).
- Overrun: set when (image_number - frames_done) mod 16 >= 2. It stays set until reset.
- Buffer selection: bm_buf = frames_done[0]. This works because writer frame n lands in buffer n mod 2.
- Word columns: wr_cols = center_cols/num_pix (19) when bm_third == 1; otherwise third_cols/num_pix (15).
- Buffer-1 offsets:
  - third_off = 15*480 = 7200
  - center_off = 19*480 = 9120
  - base = 0 when bm_buf == 0; otherwise center_off when bm_third == 1, else third_off.
- Matcher base addresses:
  - bm_base_addr_a = base
  - bm_base_addr_b = base + (third_rows/2)*wr_cols
  - The multiply uses a constant per third, computed at 16 bits; no truncation is permitted.
- bm_third, bm_buf, bm_wr_cols and the base addresses are registered. They are stable from the start pulse until the done latches complete.
- ST_IDLE:
  - If pending and enable: load bm_third = 0, clear the done latches, go to ST_LAUNCH.
- ST_LAUNCH (1 cycle):
  - Drive bm_start_a = bm_start_b = 1, go to ST_WAIT.
- ST_WAIT:
  - Set done_a_l on bm_done_a and done_b_l on bm_done_b.
  - Pulses may arrive in any order, including in the same cycle. A pulse on the same cycle as the latch check counts.
  - Done pulses received outside ST_WAIT are ignored.
  - When both latches are set (including the cycle the last pulse arrives): if bm_third == 2 go to ST_FRAME_DONE; otherwise increment bm_third, clear the latches, go to ST_LAUNCH.
- ST_FRAME_DONE (1 cycle):
  - frames_done increments and wraps 15 -> 0.
  - bm_working_buf toggles and frame_done pulses.
  - Go to ST_IDLE.
- Back-to-back frames: a new frame may launch on the cycle after ST_FRAME_DONE if it is still pending.
- Latency: the first start pulse follows 2 cycles after image_number changes (register, then ST_LAUNCH).
- Deasserting enable during a frame has no effect until the FSM returns to ST_IDLE.

Test Plan:
- Reset, then image_number 0 -> 1:
  - bm_start pulses for third 0, then third 1, then third 2.
  - Base addresses A/B: 0/3600, then 0/4560, then 0/3600.
  - wr_cols: 15, 19, 15.
  - After the final done: frame_done pulses, frames_done = 1, bm_working_buf = 1.
- image_number 1 -> 2: bm_buf = 1.
  - Base addresses A/B: 7200/10800, then 9120/13680, then 7200/10800.
  - After the frame: bm_working_buf returns to 0.
- Done arrival order:
  - bm_done_b arrives 5 cycles before bm_done_a: the next launch occurs only after done_a.
  - Both done pulses in the same cycle: the next launch follows one cycle later.
  - A spurious done in ST_IDLE: no state change.
- enable = 0 with a frame pending: stays in ST_IDLE with bm_idle = 1. Raising enable launches 2 cycles later.
- Reset asserted mid-ST_WAIT: outputs are zeroed asynchronously and the FSM is in ST_IDLE. A late done has no effect. image_number = 1 restarts the frame from third 0.
- Overrun and wrap:
  - With frames_done = 0, jumping image_number to 2 sets overrun. overrun stays set after the backlog drains.
  - Run 16 frames: frames_done wraps 15 -> 0.

Source files
------------

// File: rtl/bm_frame_scheduler.sv
// Frame scheduler for the two block matchers: walks the left, center and right thirds
// of the current read buffer, splitting rows between matcher A (top) and B (bottom).
module bm_frame_scheduler #(
  parameter int third_cols  = 240,
  parameter int center_cols = 304,
  parameter int third_rows  = 480,
  parameter int num_pix     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  image_number,
  input  logic        enable,
  output logic        bm_working_buf,
  output logic        bm_idle,
  output logic        bm_start_a,
  output logic        bm_start_b,
  input  logic        bm_done_a,
  input  logic        bm_done_b,
  output logic [1:0]  bm_third,
  output logic        bm_buf,
  output logic [4:0]  bm_wr_cols,
  output logic [15:0] bm_base_addr_a,
  output logic [15:0] bm_base_addr_b,
  output logic [8:0]  bm_row_count,
  output logic        frame_done,
  output logic [3:0]  frames_done,
  output logic        overrun
);

  localparam logic [4:0]  WR_THIRD    = 5'(third_cols / num_pix);
  localparam logic [4:0]  WR_CENTER   = 5'(center_cols / num_pix);
  localparam logic [8:0]  ROWS_HALF   = 9'(third_rows / 2);
  localparam logic [15:0] THIRD_OFF   = 16'((third_cols / num_pix) * third_rows);
  localparam logic [15:0] CENTER_OFF  = 16'((center_cols / num_pix) * third_rows);
  localparam logic [15:0] HALF_THIRD  = 16'((third_rows / 2) * (third_cols / num_pix));
  localparam logic [15:0] HALF_CENTER = 16'((third_rows / 2) * (center_cols / num_pix));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FRAME_DONE
  } state_t;

  typedef struct packed {
    logic [4:0]  wr_cols;
    logic [15:0] base_a;
    logic [15:0] base_b;
  } geom_t;

  // Word geometry of one third within one of the two buffers.
  function automatic geom_t third_geom(input logic [1:0] third, input logic buf_sel);
    geom_t g;
    logic  center;
    center    = (third == 2'd1);
    g.wr_cols = center ? WR_CENTER : WR_THIRD;
    g.base_a  = !buf_sel ? 16'd0 : (center ? CENTER_OFF : THIRD_OFF);
    g.base_b  = g.base_a + (center ? HALF_CENTER : HALF_THIRD);
    return g;
  endfunction

  state_t     state;
  logic       done_a_l, done_b_l;
  logic       done_a_now, done_b_now;
  logic       pending;
  logic [3:0] backlog;
  geom_t      g_first, g_next;

  assign pending    = (image_number != frames_done);
  assign backlog    = 4'(image_number - frames_done);
  // A pulse arriving in the same cycle as the completion check counts.
  assign done_a_now = done_a_l | bm_done_a;
  assign done_b_now = done_b_l | bm_done_b;
  assign g_first    = third_geom(2'd0, frames_done[0]);
  assign g_next     = third_geom(2'(bm_third + 2'd1), frames_done[0]);

  // Writer frame n lands in buffer n mod 2, so both track the completed count.
  assign bm_buf         = frames_done[0];
  assign bm_working_buf = frames_done[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      done_a_l       <= 1'b0;
      done_b_l       <= 1'b0;
      bm_idle        <= 1'b1;
      bm_start_a     <= 1'b0;
      bm_start_b     <= 1'b0;
      bm_third       <= 2'd0;
      bm_wr_cols     <= 5'd0;
      bm_base_addr_a <= 16'd0;
      bm_base_addr_b <= 16'd0;
      bm_row_count   <= 9'd0;
      frame_done     <= 1'b0;
      frames_done    <= 4'd0;
      overrun        <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so every state leaves them one cycle wide.
      bm_start_a <= 1'b0;
      bm_start_b <= 1'b0;
      frame_done <= 1'b0;
      if (backlog >= 4'd2) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pending && enable) begin
            bm_third       <= 2'd0;
            bm_wr_cols     <= g_first.wr_cols;
            bm_base_addr_a <= g_first.base_a;
            bm_base_addr_b <= g_first.base_b;
            bm_row_count   <= ROWS_HALF;
            done_a_l       <= 1'b0;
            done_b_l       <= 1'b0;
            bm_idle        <= 1'b0;
            state          <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          bm_start_a <= 1'b1;
          bm_start_b <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_a_now && done_b_now) begin
            done_a_l <= 1'b0;
            done_b_l <= 1'b0;
            if (bm_third == 2'd2) begin
              state <= ST_FRAME_DONE;
            end else begin
              bm_third       <= 2'(bm_third + 2'd1);
              bm_wr_cols     <= g_next.wr_cols;
              bm_base_addr_a <= g_next.base_a;
              bm_base_addr_b <= g_next.base_b;
              state          <= ST_LAUNCH;
            end
          end else begin
            done_a_l <= done_a_now;
            done_b_l <= done_b_now;
          end
        end
        ST_FRAME_DONE: begin
          frames_done <= 4'(frames_done + 4'd1);
          frame_done  <= 1'b1;
          bm_idle     <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          bm_idle <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bm_frame_scheduler.sv
// Scoreboard bench for bm_frame_scheduler: stimulus queues expected launches and frame
// completions from a geometry model; a monitor checks them as the DUT presents pulses.
module tb_bm_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  image_number;
  logic        enable;
  logic        bm_done_a, bm_done_b;
  logic        resp_done_a = 1'b0, resp_done_b = 1'b0;
  logic        man_done_a = 1'b0, man_done_b = 1'b0;
  logic        bm_working_buf, bm_idle, bm_start_a, bm_start_b, bm_buf;
  logic        frame_done, overrun;
  logic [1:0]  bm_third;
  logic [4:0]  bm_wr_cols;
  logic [15:0] bm_base_addr_a, bm_base_addr_b;
  logic [8:0]  bm_row_count;
  logic [3:0]  frames_done;

  assign bm_done_a = resp_done_a | man_done_a;
  assign bm_done_b = resp_done_b | man_done_b;

  bm_frame_scheduler dut (
    .clk(clk), .reset(reset), .image_number(image_number), .enable(enable),
    .bm_working_buf(bm_working_buf), .bm_idle(bm_idle),
    .bm_start_a(bm_start_a), .bm_start_b(bm_start_b),
    .bm_done_a(bm_done_a), .bm_done_b(bm_done_b),
    .bm_third(bm_third), .bm_buf(bm_buf), .bm_wr_cols(bm_wr_cols),
    .bm_base_addr_a(bm_base_addr_a), .bm_base_addr_b(bm_base_addr_b),
    .bm_row_count(bm_row_count), .frame_done(frame_done),
    .frames_done(frames_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected launch: exp_cyc >= 0 is an absolute cycle, -2 means "one cycle after the
  // later done pulse of the previous third", -1 means unchecked.
  typedef struct {
    int third;
    int bufsel;
    int wr_cols;
    int base_a;
    int base_b;
    int exp_cyc;
  } launch_t;

  launch_t launch_q[$];
  int      fd_q[$];
  int      model_fd = 0;   // frames the model expects completed before the next pushed frame
  int      last_pair = 0;  // cycle the later done pulse of the last third was sampled

  task automatic push_launch(input int t, input int first_cyc);
    int      cols, wpr, bufsel, off;
    launch_t r;
    cols   = (t == 1) ? 304 : 240;
    wpr    = cols / 16;
    bufsel = model_fd % 2;
    off    = bufsel ? wpr * 480 : 0;
    r = '{t, bufsel, wpr, off, off + (480 / 2) * wpr, (t == 0) ? first_cyc : -2};
    launch_q.push_back(r);
  endtask

  task automatic push_frame(input int first_cyc);
    for (int t = 0; t < 3; t++) push_launch(t, first_cyc);
    model_fd = (model_fd + 1) % 16;
    fd_q.push_back(model_fd);
  endtask

  // Monitor: compares every presented launch or frame completion with the queues.
  launch_t mon_e;
  int      mon_fd;
  always @(negedge clk) begin
    if (!reset && (bm_start_a || bm_start_b)) begin
      check("start_pair", {bm_start_a, bm_start_b}, 2'b11);
      if (launch_q.size() == 0) begin
        check("start_expected", launch_q.size(), 1);
      end else begin
        mon_e = launch_q.pop_front();
        check("third", bm_third, mon_e.third);
        check("buf", bm_buf, mon_e.bufsel);
        check("wr_cols", bm_wr_cols, mon_e.wr_cols);
        check("base_a", bm_base_addr_a, mon_e.base_a);
        check("base_b", bm_base_addr_b, mon_e.base_b);
        check("row_count", bm_row_count, 240);
        if (mon_e.exp_cyc >= 0)
          check("launch_latency", cyc, mon_e.exp_cyc);
        else if (mon_e.exp_cyc == -2)
          check("relaunch_latency", cyc, last_pair + 1);
      end
    end
    if (!reset && frame_done) begin
      if (fd_q.size() == 0) begin
        check("frame_done_expected", fd_q.size(), 1);
      end else begin
        mon_fd = fd_q.pop_front();
        check("frames_done", frames_done, mon_fd);
        check("working_buf", bm_working_buf, mon_fd % 2);
        check("idle_after_frame", bm_idle, 1);
      end
    end
  end

  // Matcher model: answers each launch with done pulses after a mode-dependent delay.
  int mode = 0;      // 0 random, 1 B five cycles before A, 2 both in the same cycle
  bit auto_resp = 1'b1;
  always begin
    @(negedge clk);
    if (auto_resp && !reset && bm_start_a) begin
      int da, db, n;
      case (mode)
        1:       begin da = 6; db = 1; end
        2:       begin da = 3; db = 3; end
        default: begin da = $urandom_range(1, 12); db = $urandom_range(1, 12); end
      endcase
      n = (da > db) ? da : db;
      for (int t = 1; t <= n; t++) begin
        @(posedge clk); #1;
        resp_done_a = (t == da);
        resp_done_b = (t == db);
      end
      @(posedge clk); #1;
      resp_done_a = 1'b0;
      resp_done_b = 1'b0;
      last_pair = cyc;
    end
  end

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(bm_idle && launch_q.size() == 0 && fd_q.size() == 0) && n < 400);
    check(name, bm_idle && launch_q.size() == 0 && fd_q.size() == 0, 1);
  endtask

  task automatic pulse_manual_done;
    @(posedge clk); #1;
    man_done_a = 1'b1;
    man_done_b = 1'b1;
    @(posedge clk); #1;
    man_done_a = 1'b0;
    man_done_b = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_idle"}, bm_idle, 1);
    check({tag, "_start"}, {bm_start_a, bm_start_b}, 0);
    check({tag, "_third"}, bm_third, 0);
    check({tag, "_buf"}, bm_buf, 0);
    check({tag, "_wr_cols"}, bm_wr_cols, 0);
    check({tag, "_base_a"}, bm_base_addr_a, 0);
    check({tag, "_base_b"}, bm_base_addr_b, 0);
    check({tag, "_row_count"}, bm_row_count, 0);
    check({tag, "_frames_done"}, frames_done, 0);
    check({tag, "_working_buf"}, bm_working_buf, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    image_number = 4'd0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;

    // Spurious done pulses while idle change nothing.
    pulse_manual_done();
    repeat (3) @(posedge clk);
    #1;
    check("spurious_idle", bm_idle, 1);
    check("spurious_frames", frames_done, 0);

    // Frame 1, buffer 0, B finishes five cycles before A.
    mode = 1;
    @(posedge clk); #1;
    image_number = 4'd1;
    push_frame(cyc + 2);
    wait_drained("frame1_drained");
    check("frame1_working_buf", bm_working_buf, 1);

    // Frame 2, buffer 1, both dones in the same cycle.
    mode = 2;
    @(posedge clk); #1;
    image_number = 4'd2;
    push_frame(cyc + 2);
    wait_drained("frame2_drained");
    check("frame2_working_buf", bm_working_buf, 0);

    // Pending frame held off by enable; dropping enable mid-frame does not abort it.
    mode = 0;
    @(posedge clk); #1;
    enable = 1'b0;
    image_number = 4'd3;
    repeat (10) @(posedge clk);
    #1;
    check("enable_low_idle", bm_idle, 1);
    enable = 1'b1;
    push_frame(cyc + 2);
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_drained("enable_frame_drained");
    check("enable_frame_count", frames_done, 3);
    check("no_overrun_yet", overrun, 0);
    enable = 1'b1;

    // Asynchronous reset in the middle of ST_WAIT, then a late done.
    auto_resp = 1'b0;
    @(posedge clk); #1;
    image_number = 4'd4;
    push_launch(0, cyc + 2);
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy", bm_idle, 0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_cleared("abort");
    image_number = 4'd0;
    model_fd = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    pulse_manual_done();
    repeat (3) @(posedge clk);
    #1;
    check("late_done_idle", bm_idle, 1);
    check("late_done_frames", frames_done, 0);
    auto_resp = 1'b1;
    @(posedge clk); #1;
    image_number = 4'd1;
    push_frame(cyc + 2);
    wait_drained("restart_drained");
    check("restart_frames", frames_done, 1);

    // Backlog of two frames sets the sticky overrun flag.
    @(posedge clk); #1;
    image_number = 4'd3;
    push_frame(cyc + 2);
    push_frame(-1);
    repeat (2) @(posedge clk);
    #1;
    check("overrun_set", overrun, 1);
    wait_drained("backlog_drained");
    check("overrun_sticky", overrun, 1);
    check("backlog_frames", frames_done, 3);

    // Sixteen more frames with random done timing: frames_done wraps through 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      image_number = 4'(image_number + 4'd1);
      push_frame(cyc + 2);
      wait_drained("wrap_frame_drained");
    end
    check("wrap_frames", frames_done, 3);
    check("wrap_working_buf", bm_working_buf, 1);
    check("launch_q_empty", launch_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
